// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encoding and bus layouts for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int STALL_W     = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 65;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_to_id_t;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    // The fetch state is implied by the valid and hold flags rather than stored separately.
    function automatic fetch_state_e fetch_state(input logic ce, input logic hold_v);
        fetch_state_e st;
        if (!ce) begin
            st = FETCH_BOOT;
        end else if (hold_v) begin
            st = FETCH_HOLD;
        end else begin
            st = FETCH_RUN;
        end
        return st;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, next-PC select, SRAM read port and a
// stall-safe {valid, pc, inst} bundle toward ID.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus
);

    logic [31:0]  pc_r;
    logic         ce_r;
    logic         redir_v_r;
    logic [31:0]  redir_pc_r;
    logic         hold_v_r;
    logic [31:0]  hold_inst_r;

    br_bus_t      br_s;
    logic         run_s;
    logic [31:0]  next_pc_s;
    logic [31:0]  inst_s;
    fetch_state_e state_s;
    if_to_id_t    bus_s;
    logic         unused_stall_s;

    assign br_s           = br_bus_t'(br_bus);
    assign run_s          = (stall[0] == NO_STOP);
    assign unused_stall_s = ^stall[STALL_W-1:1];
    assign state_s        = fetch_state(ce_r, hold_v_r);

    // Next-PC select: a redirect parked during a stall beats a live branch.
    always_comb begin
        next_pc_s = pc_r + PC_STEP;
        if (redir_v_r) begin
            next_pc_s = redir_pc_r;
        end else if (br_s.br_e) begin
            next_pc_s = br_s.br_addr;
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // Instruction source: nothing before the first fetch, the held word while stalled.
    always_comb begin
        inst_s = 32'h0000_0000;
        case (state_s)
            FETCH_BOOT: inst_s = 32'h0000_0000;
            FETCH_RUN:  inst_s = inst_sram_rdata;
            FETCH_HOLD: inst_s = hold_inst_r;
            default:    inst_s = 32'h0000_0000;
        endcase
    end

    // ID bus: fully zero until the first valid fetch so no stale PC leaks out.
    always_comb begin
        bus_s = '0;
        if (ce_r) begin
            bus_s.ce   = 1'b1;
            bus_s.pc   = pc_r;
            bus_s.inst = inst_s;
        end else begin
            bus_s = '0;
        end
    end

    assign inst_sram_en    = resetn & run_s;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = next_pc_s;
    assign inst_sram_wdata = 32'h0000_0000;
    assign if_to_id_bus    = bus_s;

    // PC, valid flag, pending redirect and hold buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_r        <= RESET_PC - PC_STEP;
            ce_r        <= 1'b0;
            redir_v_r   <= 1'b0;
            redir_pc_r  <= 32'h0000_0000;
            hold_v_r    <= 1'b0;
            hold_inst_r <= 32'h0000_0000;
        end else if (run_s) begin
            pc_r      <= next_pc_s;
            ce_r      <= 1'b1;
            redir_v_r <= 1'b0;
            hold_v_r  <= 1'b0;
        end else begin
            // Only the first redirect of a stall is kept; ID re-issues later ones itself.
            if (br_s.br_e && !redir_v_r) begin
                redir_v_r  <= 1'b1;
                redir_pc_r <= br_s.br_addr;
            end
            // First stalled cycle: SRAM still shows the word for pc_r, so capture it.
            if (ce_r && !hold_v_r) begin
                hold_v_r    <= 1'b1;
                hold_inst_r <= inst_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run
// against a PC/redirect-queue reference model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        resetn;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [64:0] if_to_id_bus;

    logic        corrupt;
    int          n_checks;
    int          n_pass;

    // Model state: architectural PC, bundle-valid flag, parked redirect targets.
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] pend_q[$];

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .br_bus          (br_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .if_to_id_bus    (if_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // SRAM model; corrupt scribbles the read port to prove the hold buffer is used.
    always @(posedge clk) begin
        if (corrupt) inst_sram_rdata <= 32'hDEAD_BEEF;
        else if (inst_sram_en) inst_sram_rdata <= word(inst_sram_addr);
    end

    function automatic logic [31:0] exp_addr();
        if (pend_q.size() > 0) return pend_q[0];
        if (br_bus[32]) return br_bus[31:0];
        return m_pc + 32'd4;
    endfunction

    function automatic logic [64:0] exp_bus();
        if (!m_ce) return 65'd0;
        return {1'b1, m_pc, word(m_pc)};
    endfunction

    function automatic logic exp_en();
        return resetn & ~stall[0];
    endfunction

    task automatic drive(input logic rst_n, input logic stl, input logic bre,
                         input logic [31:0] bra, input logic crp);
        resetn  = rst_n;
        stall   = {5'($urandom), stl};
        br_bus  = {bre, bra};
        corrupt = crp;
        #1;
    endtask

    task automatic tick();
        logic [31:0] nxt;
        nxt = exp_addr();
        @(posedge clk);
        if (!resetn) begin
            m_pc = RST_PC - 32'd4;
            m_ce = 1'b0;
            pend_q.delete();
        end else if (!stall[0]) begin
            m_pc = nxt;
            m_ce = 1'b1;
            pend_q.delete();
        end else if (br_bus[32] && pend_q.size() == 0) begin
            pend_q.push_back(br_bus[31:0]);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (if_to_id_bus !== 65'd0) $display("FAIL reset_bus got %h want 0", if_to_id_bus); else n_pass++;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL reset_en got %b want 0", inst_sram_en); else n_pass++;
        n_checks++; if (inst_sram_wen !== 4'h0 || inst_sram_wdata !== 32'h0) $display("FAIL reset_wr got %h/%h want 0/0", inst_sram_wen, inst_sram_wdata); else n_pass++;
        n_checks++; if (inst_sram_addr !== RST_PC) $display("FAIL reset_addr got %h want %h", inst_sram_addr, RST_PC); else n_pass++;
    endtask

    task automatic test_sequential();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (inst_sram_en !== 1'b1) $display("FAIL seq_en got %b want 1", inst_sram_en); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0000) $display("FAIL seq_addr0 got %h want bfc00000", inst_sram_addr); else n_pass++;
        n_checks++; if (if_to_id_bus !== 65'd0) $display("FAIL seq_boot_bus got %h want 0", if_to_id_bus); else n_pass++;
        tick();
        n_checks++; if (if_to_id_bus !== {1'b1, 32'hBFC0_0000, word(32'hBFC0_0000)}) $display("FAIL seq_bus0 got %h want %h", if_to_id_bus, {1'b1, 32'hBFC0_0000, word(32'hBFC0_0000)}); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0004) $display("FAIL seq_addr1 got %h want bfc00004", inst_sram_addr); else n_pass++;
        tick();
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0008) $display("FAIL seq_addr2 got %h want bfc00008", inst_sram_addr); else n_pass++;
        n_checks++; if (if_to_id_bus !== exp_bus()) $display("FAIL seq_bus1 got %h want %h", if_to_id_bus, exp_bus()); else n_pass++;
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0100, 1'b0);
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0100) $display("FAIL br_addr got %h want bfc00100", inst_sram_addr); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (if_to_id_bus[63:32] !== 32'hBFC0_0100) $display("FAIL br_pc got %h want bfc00100", if_to_id_bus[63:32]); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0104) $display("FAIL br_next got %h want bfc00104", inst_sram_addr); else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        logic [64:0] saved;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        saved = exp_bus();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            n_checks++; if (if_to_id_bus !== saved) $display("FAIL stall_bus%0d got %h want %h", i, if_to_id_bus, saved); else n_pass++;
            n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL stall_en%0d got %b want 0", i, inst_sram_en); else n_pass++;
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (if_to_id_bus !== saved) $display("FAIL stall_release_bus got %h want %h", if_to_id_bus, saved); else n_pass++;
        tick();
        n_checks++; if (if_to_id_bus !== {1'b1, saved[63:32] + 32'd4, word(saved[63:32] + 32'd4)}) $display("FAIL stall_after got %h want pc %h", if_to_id_bus, saved[63:32] + 32'd4); else n_pass++;
    endtask

    task automatic test_stall_redirect();
        drive(1'b1, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'hBFC0_0300, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0200) $display("FAIL redir_addr got %h want bfc00200", inst_sram_addr); else n_pass++;
        tick();
        n_checks++; if (if_to_id_bus !== {1'b1, 32'hBFC0_0200, word(32'hBFC0_0200)}) $display("FAIL redir_bus got %h want pc bfc00200", if_to_id_bus); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'hBFC0_0204) $display("FAIL redir_cleared got %h want bfc00204", inst_sram_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (inst_sram_addr !== 32'h0000_0000) $display("FAIL wrap_addr got %h want 00000000", inst_sram_addr); else n_pass++;
        tick();
        n_checks++; if (if_to_id_bus !== {1'b1, 32'h0, word(32'h0)}) $display("FAIL wrap_bus got %h want pc 0", if_to_id_bus); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 1'b1, 1'b1, 32'hBFC0_0500, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL rms_en got %b want 0", inst_sram_en); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (if_to_id_bus !== 65'd0) $display("FAIL rms_bus got %h want 0", if_to_id_bus); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (inst_sram_addr !== RST_PC) $display("FAIL rms_addr got %h want %h", inst_sram_addr, RST_PC); else n_pass++;
        tick();
        n_checks++; if (if_to_id_bus !== {1'b1, RST_PC, word(RST_PC)}) $display("FAIL rms_restart got %h want pc %h", if_to_id_bus, RST_PC); else n_pass++;
    endtask

    task automatic test_random();
        logic        r;
        logic        s;
        logic        b;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) >= 2);
            s = ($urandom_range(0, 99) < 35);
            b = ($urandom_range(0, 99) < 25);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {16'hBFC0, 14'($urandom), 2'b00};
            drive(r, s, b, a, s);
            n_checks++; if (inst_sram_en !== exp_en()) $display("FAIL rnd_en[%0d] got %b want %b", i, inst_sram_en, exp_en()); else n_pass++;
            n_checks++; if (inst_sram_addr !== exp_addr()) $display("FAIL rnd_addr[%0d] got %h want %h", i, inst_sram_addr, exp_addr()); else n_pass++;
            n_checks++; if (if_to_id_bus !== exp_bus()) $display("FAIL rnd_bus[%0d] got %h want %h", i, if_to_id_bus, exp_bus()); else n_pass++;
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_pc     = RST_PC - 32'd4;
        m_ce     = 1'b0;
        corrupt  = 1'b0;
        resetn   = 1'b0;
        stall    = 6'd0;
        br_bus   = 33'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_stall_redirect();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
